// File: rtl/acc_cpu_core_p.sv
// rtl/acc_cpu_core_p.sv - parametrised accumulator CPU core; define ACC_SAT_EN for saturating ADD/SUB
module acc_cpu_core_p #(
  parameter int DW = 8,
  parameter int RA = 4,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          CLB,
  output logic          imem_req,
  output logic [PW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [RA+3:0] imem_data,
  output logic [PW-1:0] pc,
  output logic [DW-1:0] accum_value,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halted
);

  localparam int IW = 4 + RA;
  localparam int NR = 1 << RA;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_pc;
  logic [DW-1:0]   r_acc;
  logic            r_z;
  logic            r_c;
  logic [IW-1:0]   r_ir;
  logic [DW-1:0]   r_regs [NR];

  logic [3:0]      w_op;
  logic [RA-1:0]   w_a;
  logic [DW-1:0]   w_rv;
  logic [DW-1:0]   w_imm;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_diff;
  logic [PW-1:0]   w_pc_inc;
  logic [PW-1:0]   w_jmp;
  logic            w_req;
  logic [PW-1:0]   w_pc_n;
  logic [DW-1:0]   w_acc_n;
  logic            w_acc_wr;
  logic            w_z_n;
  logic            w_c_n;
  logic            w_reg_we;

  assign w_op     = r_ir[IW-1:RA];
  assign w_a      = r_ir[RA-1:0];
  assign w_rv     = r_regs[w_a];
  assign w_imm    = DW'(w_a);
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_rv};
  // Top bit of the widened difference is the borrow, i.e. acc < R[a]
  assign w_diff   = {1'b0, r_acc} - {1'b0, w_rv};
  assign w_pc_inc = r_pc + PW'(1);
  assign w_jmp    = PW'(w_rv);

  assign imem_req    = w_req & ~CLB;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign accum_value = r_acc;
  assign flag_z      = r_z;
  assign flag_c      = r_c;
  assign halted      = (r_state == S_HALT);

  // Next-state, fetch request and single-cycle execution of the latched instruction
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_pc_n       = r_pc;
    w_acc_n      = r_acc;
    w_acc_wr     = 1'b0;
    w_c_n        = r_c;
    w_reg_we     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_next_state = S_FETCH;
        w_pc_n       = w_pc_inc;
        case (w_op)
          OP_NOP: ;
          OP_LDI: begin w_acc_n = w_imm; w_acc_wr = 1'b1; end
          OP_LDR: begin w_acc_n = w_rv;  w_acc_wr = 1'b1; end
          OP_STR: w_reg_we = 1'b1;
          OP_ADD: begin
`ifdef ACC_SAT_EN
            w_acc_n = w_sum[DW] ? '1 : w_sum[DW-1:0];
`else
            w_acc_n = w_sum[DW-1:0];
`endif
            w_c_n    = w_sum[DW];
            w_acc_wr = 1'b1;
          end
          OP_SUB: begin
`ifdef ACC_SAT_EN
            w_acc_n = w_diff[DW] ? '0 : w_diff[DW-1:0];
`else
            w_acc_n = w_diff[DW-1:0];
`endif
            w_c_n    = w_diff[DW];
            w_acc_wr = 1'b1;
          end
          OP_AND: begin w_acc_n = r_acc & w_rv; w_acc_wr = 1'b1; end
          OP_OR:  begin w_acc_n = r_acc | w_rv; w_acc_wr = 1'b1; end
          OP_XOR: begin w_acc_n = r_acc ^ w_rv; w_acc_wr = 1'b1; end
          OP_NOT: begin w_acc_n = ~r_acc;       w_acc_wr = 1'b1; end
          OP_SHL: begin
            w_c_n    = r_acc[DW-1];
            w_acc_n  = {r_acc[DW-2:0], 1'b0};
            w_acc_wr = 1'b1;
          end
          OP_SHR: begin
            w_c_n    = r_acc[0];
            w_acc_n  = {1'b0, r_acc[DW-1:1]};
            w_acc_wr = 1'b1;
          end
          OP_JMP: w_pc_n = w_jmp;
          OP_JZ:  if (r_z) w_pc_n = w_jmp;
          OP_JC:  if (r_c) w_pc_n = w_jmp;
          OP_HLT: begin
            w_next_state = S_HALT;
            w_pc_n       = r_pc;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: w_next_state = S_FETCH;
    endcase
    // Zero flag follows the new accumulator only for ops that write it
    w_z_n = w_acc_wr ? (w_acc_n == '0) : r_z;
  end

  // State register
  always_ff @(posedge clk) begin
    if (CLB) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  // Architectural state: IR capture on an accepted fetch, commit of the executed instruction
  always_ff @(posedge clk) begin
    if (CLB) begin
      r_pc  <= '0;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      r_ir  <= '0;
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_ir <= imem_data;
      r_pc  <= w_pc_n;
      r_acc <= w_acc_n;
      r_z   <= w_z_n;
      r_c   <= w_c_n;
      if (w_reg_we) r_regs[w_a] <= r_acc;
    end
  end

endmodule

// File: tb/tb_acc_cpu_core_p.sv
// tb/tb_acc_cpu_core_p.sv - self-checking bench for acc_cpu_core_p (ACC_SAT_EN selects saturating expectations)
module tb_acc_cpu_core_p;

  localparam int DW    = 8;
  localparam int RA    = 4;
  localparam int PW    = 8;
  localparam int IW    = 4 + RA;
  localparam int DMASK = (1 << DW) - 1;
  localparam int AMASK = (1 << RA) - 1;
  localparam int PMOD  = 1 << PW;
`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          CLB;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [PW-1:0] pc;
  logic [DW-1:0] accum_value;
  logic          flag_z;
  logic          flag_c;
  logic          halted;

  always #5 clk = ~clk;

  acc_cpu_core_p #(.DW(DW), .RA(RA), .PW(PW)) dut (
    .clk        (clk),
    .CLB        (CLB),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .pc         (pc),
    .accum_value(accum_value),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .halted     (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic [IW-1:0] prog [PMOD];
  int stall_pc   = -1;
  int stall_left = 0;

  // Instruction-level model: phase 0 fetch, 1 execute, 2 halted
  int m_phase = 0;
  int m_pc = 0;
  int m_acc = 0;
  int m_ir = 0;
  bit m_z = 1'b0;
  bit m_c = 1'b0;
  int m_regs [1 << RA];
  int tr_acc [PMOD];
  int tr_npc [PMOD];
  bit tr_z [PMOD];
  bit tr_c [PMOD];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_acc(input int v);
    m_acc = v;
    m_z   = (v == 0);
  endtask

  task automatic model_exec();
    int op, a, r, s, npc, at;
    op  = (m_ir >> RA) & 15;
    a   = m_ir & AMASK;
    r   = m_regs[a];
    at  = m_pc;
    npc = (m_pc + 1) % PMOD;
    m_phase = 0;
    case (op)
      1:  set_acc(a);
      2:  set_acc(r);
      3:  m_regs[a] = m_acc;
      4:  begin s = m_acc + r; m_c = (s > DMASK); set_acc((SAT && m_c) ? DMASK : (s & DMASK)); end
      5:  begin m_c = (m_acc < r); set_acc((SAT && m_c) ? 0 : ((m_acc - r) & DMASK)); end
      6:  set_acc(m_acc & r);
      7:  set_acc(m_acc | r);
      8:  set_acc(m_acc ^ r);
      9:  set_acc(DMASK - m_acc);
      10: begin m_c = (m_acc >= (1 << (DW - 1))); set_acc((m_acc * 2) & DMASK); end
      11: begin m_c = ((m_acc % 2) == 1); set_acc(m_acc / 2); end
      12: npc = r % PMOD;
      13: if (m_z) npc = r % PMOD;
      14: if (m_c) npc = r % PMOD;
      15: begin npc = m_pc; m_phase = 2; end
      default: ;
    endcase
    m_pc = npc;
    tr_acc[at] = m_acc;
    tr_z[at]   = m_z;
    tr_c[at]   = m_c;
    tr_npc[at] = npc;
  endtask

  always @(posedge clk) begin
    if (CLB) begin
      m_phase = 0; m_pc = 0; m_acc = 0; m_ir = 0; m_z = 1'b0; m_c = 1'b0;
      foreach (m_regs[i]) m_regs[i] = 0;
      foreach (tr_acc[i]) begin tr_acc[i] = -1; tr_npc[i] = -1; tr_z[i] = 1'b0; tr_c[i] = 1'b0; end
    end else if (m_phase == 0) begin
      if (imem_ack) begin m_ir = int'(imem_data); m_phase = 1; end
    end else if (m_phase == 1) begin
      model_exec();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("req",    32'(imem_req),    32'((m_phase == 0) && !CLB));
      check("addr",   32'(imem_addr),   m_pc);
      check("pc",     32'(pc),          m_pc);
      check("acc",    32'(accum_value), m_acc);
      check("z",      32'(flag_z),      32'(m_z));
      check("c",      32'(flag_c),      32'(m_c));
      check("halted", 32'(halted),      32'(m_phase == 2));
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
    if (m_phase == 0 && m_pc == stall_pc && stall_left > 0) begin
      imem_ack = 1'b0;
      stall_left--;
    end else begin
      imem_ack = 1'b1;
    end
    imem_data = prog[m_pc];
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    CLB = 1'b1; imem_ack = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("rst_req",    32'(imem_req),    0);
    check("rst_pc",     32'(pc),          0);
    check("rst_acc",    32'(accum_value), 0);
    check("rst_z",      32'(flag_z),      0);
    check("rst_c",      32'(flag_c),      0);
    check("rst_halted", 32'(halted),      0);
    CLB = 1'b0;
    imem_data = prog[0];
    @(negedge clk);
    check("rel_req",  32'(imem_req),  1);
    check("rel_addr", 32'(imem_addr), 0);
  endtask

  task automatic run_to_halt(input string nm, input int exp_k);
    int k;
    k = 0;
    while (m_phase != 2 && k < exp_k + 50) begin
      cycle();
      k++;
    end
    check(nm, k, exp_k);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    CLB = 1'b1; imem_ack = 1'b1; imem_data = '0;

    // LDI F; STR R1; ADD R1; LDI F; SHL x4 (stalled fetch at 7); STR R2; ADD R2; HLT
    clear_prog();
    prog[0] = 'h1F; prog[1] = 'h31; prog[2] = 'h41; prog[3] = 'h1F;
    prog[4] = 'hA0; prog[5] = 'hA0; prog[6] = 'hA0; prog[7] = 'hA0;
    prog[8] = 'h32; prog[9] = 'h42; prog[10] = 'hF0;
    stall_pc = 7; stall_left = 3;
    do_reset();
    run_to_halt("p1_cycles", 25);
    check("p1_add1_acc", tr_acc[2], 'h1E);
    check("p1_add1_z",   32'(tr_z[2]), 0);
    check("p1_add1_c",   32'(tr_c[2]), 0);
    check("p1_shl_acc",  tr_acc[7], 'hF0);
    check("p1_add2_acc", tr_acc[9], SAT ? 'hFF : 'hE0);
    check("p1_add2_c",   32'(tr_c[9]), 1);

    // Build R3=0x20; LDI 5; STR R4; SUB R4; JC R3; JZ R3 -> 0x20; LDI 9; STR R6; JMP R6 -> HLT at 9
    stall_pc = -1;
    clear_prog();
    prog[0] = 'h18; prog[1] = 'hA0; prog[2] = 'hA0; prog[3] = 'h33;
    prog[4] = 'h15; prog[5] = 'h34; prog[6] = 'h54; prog[7] = 'hE3;
    prog[8] = 'hD3; prog[9] = 'hF0;
    prog['h20] = 'h19; prog['h21] = 'h36; prog['h22] = 'hC6;
    do_reset();
    run_to_halt("p2_cycles", 26);
    check("p2_sub_acc", tr_acc[6], 0);
    check("p2_sub_z",   32'(tr_z[6]), 1);
    check("p2_sub_c",   32'(tr_c[6]), 0);
    check("p2_jc_npc",  tr_npc[7], 8);
    check("p2_jz_npc",  tr_npc[8], 'h20);
    check("p2_jmp_npc", tr_npc['h22], 9);
    repeat (12) cycle();
    @(negedge clk);
    check("p2_halt_pc",  32'(pc), 9);
    check("p2_halted",   32'(halted), 1);
    check("p2_halt_req", 32'(imem_req), 0);

    // All-NOP program: pc runs through 0xFF and wraps to 0
    clear_prog();
    do_reset();
    k = 0;
    while (!(m_pc == PMOD - 1 && m_phase == 0) && k < 1000) begin
      cycle();
      k++;
    end
    check("p3_reach_ff", k, 510);
    cycle();
    cycle();
    @(negedge clk);
    check("p3_wrap_addr", 32'(imem_addr), 0);
    check("p3_wrap_npc",  tr_npc[PMOD-1], 0);

    // R5=0x20, acc=0xF0, ADD R5; then acc=0x10, SUB R5; HLT
    clear_prog();
    prog[0] = 'h18; prog[1] = 'hA0; prog[2] = 'hA0; prog[3] = 'h35;
    prog[4] = 'h1F; prog[5] = 'hA0; prog[6] = 'hA0; prog[7] = 'hA0;
    prog[8] = 'hA0; prog[9] = 'h45; prog[10] = 'h11; prog[11] = 'hA0;
    prog[12] = 'hA0; prog[13] = 'hA0; prog[14] = 'hA0; prog[15] = 'h55;
    prog[16] = 'hF0;
    do_reset();
    run_to_halt("p4_cycles", 34);
    check("p4_pre_acc", tr_acc[8], 'hF0);
    check("p4_add_acc", tr_acc[9], SAT ? 'hFF : 'h10);
    check("p4_add_c",   32'(tr_c[9]), 1);
    check("p4_add_z",   32'(tr_z[9]), 0);
    check("p4_sub_in",  tr_acc[14], 'h10);
    check("p4_sub_acc", tr_acc[15], SAT ? 'h00 : 'hF0);
    check("p4_sub_z",   32'(tr_z[15]), SAT ? 1 : 0);
    check("p4_sub_c",   32'(tr_c[15]), 1);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
